// File: rtl/ddr_traffic_checker_if.sv
// Memory-controller user port: burst command channel, write-beat channel and unthrottled read-beat return.
// master = traffic checker side, slave = memory controller side.
interface ddr_traffic_checker_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, wdata_valid, wdata,
        input  cmd_ready, wdata_ready, rdata_valid, rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, wdata_valid, wdata,
        output cmd_ready, wdata_ready, rdata_valid, rdata
    );
endinterface

// File: rtl/ddr_traffic_checker.sv
// DDR traffic generator/checker: writes NUM_BURSTS pattern bursts, reads them back, counts mismatching beats.
// Latency: error_count/first_err_addr update one cycle after the rdata beat; valid/ready stalls hold state with no loss.
// Define DDR_TC_ERR_INJECT_EN to flip bit 0 of the last write beat of burst 0 (end-to-end checker self-test).
module ddr_traffic_checker #(
    parameter int          ADDR_WIDTH = 28,
    parameter int          DATA_WIDTH = 128,
    parameter int          BURST_LEN  = 8,
    parameter int          NUM_BURSTS = 1024,
    parameter logic [31:0] SEED       = 32'hACE1_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    ddr_traffic_checker_if.master   mem,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             error_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr
);
    localparam int          BEAT_BYTES = DATA_WIDTH / 8;
    localparam int          BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int          CW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int          WW         = $clog2(DATA_WIDTH);
    localparam int          REP        = DATA_WIDTH / 32;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [BW-1:0]         beat_cnt;
    logic [CW-1:0]         burst_cnt;
    logic [WW-1:0]         walk_idx;
    logic [31:0]           lfsr;
    logic                  odd_beat;

    logic                  cmd_vld, cmd_wr, wr_vld;
    logic                  go, beat_fire, gen_reload, last_beat, last_burst;
    logic                  chk_err;
    logic [DATA_WIDTH-1:0] pattern, wr_beat;

    assign go         = start && (state == IDLE || state == DONE);
    assign last_beat  = (beat_cnt == BW'(BURST_LEN - 1));
    assign last_burst = (burst_cnt == CW'(NUM_BURSTS - 1));
    assign beat_fire  = (state == WR_DATA && mem.wdata_ready) || (state == RD_DATA && mem.rdata_valid);
    // Generator restarts at the top of both phases so reads regenerate exactly what was written.
    assign gen_reload = go || (state == WR_DATA && mem.wdata_ready && last_beat && last_burst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_vld   = 1'b0;
        cmd_wr    = 1'b0;
        wr_vld    = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_nxt = WR_CMD;
            WR_CMD: begin
                cmd_vld = 1'b1;
                cmd_wr  = 1'b1;
                if (mem.cmd_ready) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                wr_vld = 1'b1;
                if (mem.wdata_ready && last_beat) state_nxt = last_burst ? RD_CMD : WR_CMD;
            end
            RD_CMD: begin
                cmd_vld = 1'b1;
                if (mem.cmd_ready) state_nxt = RD_DATA;
            end
            RD_DATA: if (mem.rdata_valid && last_beat) state_nxt = last_burst ? DONE : RD_CMD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pattern = '0;
        case (mode_q)
            2'd0:    pattern = {REP{32'(beat_addr)}};
            2'd1:    pattern = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << walk_idx;
            2'd2:    pattern = {REP{lfsr}};
            default: pattern = {REP{odd_beat ? 32'h5555_5555 : 32'hAAAA_AAAA}};
        endcase
    end

`ifdef DDR_TC_ERR_INJECT_EN
    logic inject;
    assign inject  = (state == WR_DATA) && (burst_cnt == '0) && last_beat;
    assign wr_beat = pattern ^ {{(DATA_WIDTH-1){1'b0}}, inject};
`else
    assign wr_beat = pattern;
`endif

    // Burst start and beat address coincide in the command states, so one counter serves both.
    assign mem.cmd_valid   = cmd_vld;
    assign mem.cmd_write   = cmd_wr;
    assign mem.cmd_addr    = beat_addr;
    assign mem.wdata_valid = wr_vld;
    assign mem.wdata       = wr_vld ? wr_beat : '0;

    assign busy = (state == WR_CMD) || (state == WR_DATA) || (state == RD_CMD) || (state == RD_DATA);
    assign done = (state == DONE);
    assign pass = done && (error_count == 16'd0);

    // Any read beat outside the read-data phase is unexpected traffic and counts as an error.
    assign chk_err = mem.rdata_valid && ((state != RD_DATA) || (mem.rdata != pattern));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 2'd0;
            base_q    <= '0;
            beat_addr <= '0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            walk_idx  <= '0;
            lfsr      <= '0;
            odd_beat  <= 1'b0;
        end else begin
            if (go) begin
                mode_q <= mode;
                base_q <= base_addr;
            end
            if (gen_reload) begin
                beat_addr <= go ? base_addr : base_q;
                beat_cnt  <= '0;
                burst_cnt <= '0;
                walk_idx  <= '0;
                lfsr      <= SEED;
                odd_beat  <= 1'b0;
            end else if (beat_fire) begin
                beat_addr <= beat_addr + ADDR_WIDTH'(BEAT_BYTES);
                beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
                if (last_beat) burst_cnt <= last_burst ? '0 : burst_cnt + 1'b1;
                walk_idx  <= (walk_idx == WW'(DATA_WIDTH - 1)) ? '0 : walk_idx + 1'b1;
                lfsr      <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
                odd_beat  <= ~odd_beat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_count    <= '0;
            first_err_addr <= '0;
        end else if (go) begin
            error_count    <= '0;
            first_err_addr <= '0;
        end else if (chk_err) begin
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            if (error_count == 16'd0 && state == RD_DATA) first_err_addr <= beat_addr;
        end
    end
endmodule

// File: tb/tb_ddr_traffic_checker.sv
// Bench for ddr_traffic_checker: ideal RAM with 1-cycle read latency, random stalls, table rows plus random passes.
module tb_ddr_traffic_checker;
    localparam int          AW     = 28;
    localparam int          DW     = 32;
    localparam int          BL     = 4;
    localparam int          NB     = 4;
    localparam int          NBEATS = BL * NB;
    localparam logic [31:0] SEED   = 32'hACE1_0001;
`ifdef DDR_TC_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic          busy, done, pass;
    logic [15:0]   error_count;
    logic [AW-1:0] first_err_addr;

    ddr_traffic_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    ddr_traffic_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(NB), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr), .mem(mem),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pass context shared between the sequencer and the RAM responder.
    logic [1:0]    cur_mode;
    logic [AW-1:0] cur_base;
    bit            rnd, cor_en, stray_req;
    logic [AW-1:0] cor_addr;
    int            cmd_idx, wn, rn, exp_cnt;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] rq[$];
    logic [AW-1:0] cmd_log[$];
    logic [DW-1:0] ram[logic [AW-1:0]];

    typedef struct {
        logic [1:0]    mode;
        logic [AW-1:0] base;
        bit            rnd;
        bit            cor_en;
        logic [AW-1:0] cor_addr;
        bit            exp_pass;
        int            exp_err;
        logic [AW-1:0] exp_first;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pattern of global beat n written for a pass starting at base.
    function automatic logic [DW-1:0] model_beat(input logic [1:0] m, input int n, input logic [AW-1:0] base);
        logic [31:0]   l;
        logic [AW-1:0] a;
        a = base + AW'(n * (DW / 8));
        case (m)
            2'd0: return {4'h0, a};
            2'd1: return 32'h1 << (n % DW);
            2'd2: begin
                l = SEED;
                for (int k = 0; k < n; k++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
                return l;
            end
            default: return (n % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
        endcase
    endfunction

    // RAM responder: everything happens on the falling edge, so the DUT sees stable inputs at each rising edge.
    initial begin : responder
        logic [AW-1:0] a, ea;
        logic [DW-1:0] d;
        mem.cmd_ready   = 1'b0;
        mem.wdata_ready = 1'b0;
        mem.rdata_valid = 1'b0;
        mem.rdata       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rq.delete();
                mem.rdata_valid = 1'b0;
                mem.cmd_ready   = 1'b0;
                mem.wdata_ready = 1'b0;
            end else begin
                if (busy) begin
                    check("err_count_cycle", 64'(error_count), 64'(exp_cnt));
                    check("first_err_cycle", 64'(first_err_addr), 64'(exp_cnt > 0 ? exp_first : '0));
                end
                mem.rdata_valid = 1'b0;
                mem.rdata       = '0;
                if (stray_req) begin
                    mem.rdata_valid = 1'b1;
                    stray_req = 1'b0;
                end else if (rq.size() > 0) begin
                    a = rq.pop_front();
                    d = ram.exists(a) ? ram[a] : '0;
                    if (cor_en && a == cor_addr) d[5] = ~d[5];
                    mem.rdata_valid = 1'b1;
                    mem.rdata       = d;
                    if ((INJ && rn == BL - 1) || (cor_en && a == cor_addr)) begin
                        if (exp_cnt == 0) exp_first = a;
                        exp_cnt++;
                    end
                    rn++;
                end
                mem.cmd_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                mem.wdata_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mem.cmd_valid && mem.cmd_ready) begin
                    ea = cur_base + AW'((cmd_idx % NB) * BL * (DW / 8));
                    check("cmd_addr", 64'(mem.cmd_addr), 64'(ea));
                    check("cmd_write", 64'(mem.cmd_write), 64'(cmd_idx < NB));
                    cmd_log.push_back(mem.cmd_addr);
                    if (!mem.cmd_write)
                        for (int b = 0; b < BL; b++) rq.push_back(mem.cmd_addr + AW'(b * (DW / 8)));
                    cmd_idx++;
                end
                if (mem.wdata_valid && mem.wdata_ready) begin
                    check("wdata", 64'(mem.wdata),
                          64'(model_beat(cur_mode, wn, cur_base) ^ ((INJ && wn == BL - 1) ? 32'h1 : 32'h0)));
                    ram[cur_base + AW'(wn * (DW / 8))] = mem.wdata;
                    wn++;
                end
            end
        end
    end

    task automatic arm_pass(input logic [1:0] m, input logic [AW-1:0] b, input bit r,
                            input bit ce, input logic [AW-1:0] ca);
        cur_mode = m; cur_base = b; rnd = r; cor_en = ce; cor_addr = ca;
        cmd_idx = 0; wn = 0; rn = 0; exp_cnt = 0; exp_first = '0;
        cmd_log.delete();
        mode = m; base_addr = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_cleared", 64'(done), 64'd0);
    endtask

    task automatic run_pass(input logic [1:0] m, input logic [AW-1:0] b, input bit r,
                            input bit ce, input logic [AW-1:0] ca, input bit poke);
        bit ok;
        arm_pass(m, b, r, ce, ca);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            start = poke && (c == 5);
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pass_timeout: done=0 after 3000 cycles, required done=1");
        end
        check("cmd_count", 64'(cmd_idx), 64'(2 * NB));
        check("wbeat_count", 64'(wn), 64'(NBEATS));
        check("rbeat_count", 64'(rn), 64'(NBEATS));
        check("busy_at_done", 64'(busy), 64'd0);
    endtask

    initial begin : main
        vec_t          vt[5];
        int            ecnt, ci;
        logic [AW-1:0] efirst, rb, ca;
        logic [1:0]    rm;
        bit            ce, found;

        rst = 1'b1; start = 1'b0; mode = 2'd0; base_addr = '0;
        rnd = 1'b0; cor_en = 1'b0; cor_addr = '0; stray_req = 1'b0;
        cur_mode = 2'd0; cur_base = '0; cmd_idx = 0; wn = 0; rn = 0; exp_cnt = 0; exp_first = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err", 64'(error_count), 64'd0);
        check("rst_first", 64'(first_err_addr), 64'd0);
        check("rst_cmd_valid", 64'(mem.cmd_valid), 64'd0);
        check("rst_cmd_addr", 64'(mem.cmd_addr), 64'd0);
        check("rst_wdata_valid", 64'(mem.wdata_valid), 64'd0);
        check("rst_wdata", 64'(mem.wdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vt[0] = '{2'd0, 28'h100, 1'b0, 1'b0, 28'h0, !INJ, INJ ? 1 : 0, INJ ? 28'h10C : 28'h0};
        vt[1] = '{2'd2, 28'h2000, 1'b1, 1'b0, 28'h0, !INJ, INJ ? 1 : 0, INJ ? 28'h200C : 28'h0};
        vt[2] = '{2'd1, 28'h100, 1'b0, 1'b1, 28'h118, 1'b0, INJ ? 2 : 1, INJ ? 28'h10C : 28'h118};
        vt[3] = '{2'd3, 28'hFFFFFF0, 1'b1, 1'b0, 28'h0, !INJ, INJ ? 1 : 0, INJ ? 28'hFFFFFFC : 28'h0};
        vt[4] = '{2'd1, 28'h0, 1'b0, 1'b0, 28'h0, !INJ, INJ ? 1 : 0, INJ ? 28'hC : 28'h0};

        for (int i = 0; i < 5; i++) begin
            run_pass(vt[i].mode, vt[i].base, vt[i].rnd, vt[i].cor_en, vt[i].cor_addr, i == 1);
            check($sformatf("v%0d_done", i), 64'(done), 64'd1);
            check($sformatf("v%0d_pass", i), 64'(pass), 64'(vt[i].exp_pass));
            check($sformatf("v%0d_err", i), 64'(error_count), 64'(vt[i].exp_err));
            check($sformatf("v%0d_first", i), 64'(first_err_addr), 64'(vt[i].exp_first));
            if (i == 3) check("wrap_cmd_addr", 64'(cmd_log.size() > 1 ? cmd_log[1] : 28'hFFFFFFF), 64'd0);
        end

        // Reset in the middle of the write-data phase.
        arm_pass(2'd0, 28'h400, 1'b1, 1'b0, 28'h0);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (mem.wdata_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wdata_wait: wdata_valid=0 after 200 cycles, required 1");
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cmd_valid", 64'(mem.cmd_valid), 64'd0);
        check("midrst_wdata_valid", 64'(mem.wdata_valid), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_pass(2'd0, 28'h400, 1'b1, 1'b0, 28'h0, 1'b0);
        check("postrst_pass", 64'(pass), 64'(!INJ));
        check("postrst_err", 64'(error_count), 64'(INJ ? 1 : 0));
        check("postrst_first", 64'(first_err_addr), 64'(INJ ? 28'h40C : 28'h0));

        // Stray read beat while idle in DONE: one more error, no address capture.
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_err", 64'(error_count), 64'(INJ ? 2 : 1));
        check("stray_first", 64'(first_err_addr), 64'(INJ ? 28'h40C : 28'h0));
        check("stray_pass", 64'(pass), 64'd0);
        check("stray_done", 64'(done), 64'd1);

        for (int i = 0; i < 6; i++) begin
            rm = 2'($urandom_range(0, 3));
            rb = AW'($urandom);
            ce = 1'($urandom_range(0, 1));
            ci = int'($urandom_range(0, NBEATS - 1));
            ca = rb + AW'(ci * (DW / 8));
            ecnt = 0;
            efirst = '0;
            for (int n = 0; n < NBEATS; n++) begin
                if ((INJ && n == BL - 1) || (ce && n == ci)) begin
                    if (ecnt == 0) efirst = rb + AW'(n * (DW / 8));
                    ecnt++;
                end
            end
            run_pass(rm, rb, 1'b1, ce, ca, 1'b0);
            check($sformatf("r%0d_pass", i), 64'(pass), 64'(ecnt == 0));
            check($sformatf("r%0d_err", i), 64'(error_count), 64'(ecnt));
            check($sformatf("r%0d_first", i), 64'(first_err_addr), 64'(efirst));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
